fifo_drain_reader: RTL and testbench

//  Consumer side of the FIFO: pairs with the FIFO control unit plus its dual-port RAM.

---
 rtl/fifo_drain_reader.sv | 89 ++++++++
 tb/tb_fifo_drain_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// Pulls words out of a FIFO/RAM pair into a 2-entry skid buffer and offers them on valid/ready.
// Read-to-valid latency is 2 cycles; reads stall once buffered plus in-flight words would exceed 2.
module fifo_drain_reader #(
    parameter int width = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_rdata,
    output logic             fifo_read,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pop_count,
    output logic             busy
);

    logic [1:0]       occ;
    logic [1:0]       occ_nxt;
    logic             inflight;
    logic [width-1:0] head_q;
    logic [width-1:0] head_nxt;
    logic [width-1:0] tail_q;
    logic [width-1:0] tail_nxt;
    logic             deq;
    logic [1:0]       level_after;

    // occ + inflight never exceeds 2, so the 2-bit sum cannot overflow.
    always_comb begin
        out_valid   = (occ != 2'd0);
        out_data    = out_valid ? head_q : '0;
        deq         = out_valid && out_ready;
        level_after = occ + {1'b0, inflight} - {1'b0, deq};
        fifo_read   = drain_en && !fifo_empty && (level_after < 2'd2);
        busy        = out_valid || inflight;
    end

    always_comb begin
        occ_nxt  = occ;
        head_nxt = head_q;
        tail_nxt = tail_q;
        case ({inflight, deq})
            2'b10: begin
                if (occ == 2'd0) begin
                    head_nxt = fifo_rdata;
                end else begin
                    tail_nxt = fifo_rdata;
                end
                occ_nxt = occ + 2'd1;
            end
            2'b01: begin
                head_nxt = (occ == 2'd2) ? tail_q : '0;
                tail_nxt = '0;
                occ_nxt  = occ - 2'd1;
            end
            // Capture and dequeue together: head advances, new word lands behind it.
            2'b11: begin
                if (occ == 2'd2) begin
                    head_nxt = tail_q;
                    tail_nxt = fifo_rdata;
                end else begin
                    head_nxt = fifo_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            pop_count <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= fifo_read;
            head_q   <= head_nxt;
            tail_q   <= tail_nxt;
            if (deq) begin
                pop_count <= pop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Bench for fifo_drain_reader: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fifo_drain_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drain_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [3:0] fifo_rdata = 4'h0;
    logic       out_ready = 1'b0;

    logic       fifo_read_a, out_valid_a, busy_a;
    logic [3:0] out_data_a;
    logic [7:0] pop_count_a;
    logic       fifo_read_b, out_valid_b, busy_b;
    logic [3:0] out_data_b;
    logic [1:0] pop_count_b;

    int errors = 0;
    int checks = 0;

    logic [3:0] src[$];
    logic [3:0] mq[$];
    logic [3:0] got[$];
    logic       m_infl = 1'b0;
    logic [3:0] m_word = 4'h0;
    int         m_cnt = 0;
    logic       m_valid, m_deq, m_rd, m_busy;
    logic [3:0] m_data;
    int         nreads;

    fifo_drain_reader #(.width(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .drain_en(drain_en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_read(fifo_read_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .pop_count(pop_count_a), .busy(busy_a)
    );

    fifo_drain_reader #(.width(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .drain_en(drain_en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_read(fifo_read_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .pop_count(pop_count_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO emulation: empty flag follows the source queue just after each edge.
    always @(posedge clk) begin
        #1;
        fifo_empty = (src.size() == 0);
    end

    // Reference model: buffer is a queue, in-flight word joins it one edge after its read.
    always @(negedge clk) begin
        if ($time > 5) begin
            m_valid = (mq.size() != 0);
            m_data  = m_valid ? mq[0] : 4'h0;
            m_deq   = m_valid && out_ready;
            m_rd    = drain_en && !fifo_empty && ((mq.size() + int'(m_infl) - int'(m_deq)) < 2);
            m_busy  = m_valid || m_infl;
            check("a_fifo_read", int'(fifo_read_a), int'(m_rd));
            check("a_out_valid", int'(out_valid_a), int'(m_valid));
            check("a_out_data", int'(out_data_a), int'(m_data));
            check("a_busy", int'(busy_a), int'(m_busy));
            check("a_pop_count", int'(pop_count_a), m_cnt % 256);
            check("b_fifo_read", int'(fifo_read_b), int'(m_rd));
            check("b_out_valid", int'(out_valid_b), int'(m_valid));
            check("b_out_data", int'(out_data_b), int'(m_data));
            check("b_busy", int'(busy_b), int'(m_busy));
            check("b_pop_count", int'(pop_count_b), m_cnt % 4);
            fifo_rdata = m_word;
            if (reset) begin
                mq.delete();
                src.delete();
                m_infl = 1'b0;
                m_cnt  = 0;
            end else begin
                if (m_deq) begin
                    void'(mq.pop_front());
                    m_cnt++;
                end
                if (m_infl) mq.push_back(m_word);
                m_infl = m_rd;
                if (m_rd && src.size() != 0) m_word = src.pop_front();
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drain_en = 1'b0;
        out_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rst_fifo_read", int'(fifo_read_a), 0);
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_data", int'(out_data_a), 0);
        check("rst_pop_count", int'(pop_count_a), 0);
        check("rst_busy", int'(busy_a), 0);

        // Single word
        do_reset();
        src.push_back(4'hA);
        out_ready = 1'b1;
        cyc(1);
        drain_en = 1'b1;
        @(negedge clk);
        check("single_read_c0", int'(fifo_read_a), 1);
        @(negedge clk);
        check("single_valid_c1", int'(out_valid_a), 0);
        @(negedge clk);
        check("single_valid_c2", int'(out_valid_a), 1);
        check("single_data_c2", int'(out_data_a), 'hA);
        @(negedge clk);
        check("single_pop_count", int'(pop_count_a), 1);

        // Stream of five words
        do_reset();
        for (int w = 1; w <= 5; w++) src.push_back(4'(w));
        out_ready = 1'b1;
        cyc(1);
        drain_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("stream_read", int'(fifo_read_a), (i < 5) ? 1 : 0);
            check("stream_valid", int'(out_valid_a), (i >= 2 && i < 7) ? 1 : 0);
            if (i >= 2 && i < 7) check("stream_data", int'(out_data_a), i - 1);
        end
        check("stream_pop_count", int'(pop_count_a), 5);
        check("wrap_pop_count", int'(pop_count_b), 1);
        check("stream_busy_end", int'(busy_a), 0);

        // Backpressure
        do_reset();
        for (int w = 1; w <= 5; w++) src.push_back(4'(w));
        out_ready = 1'b0;
        cyc(1);
        drain_en = 1'b1;
        nreads = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_read_a) nreads++;
            if (i >= 2) check("bp_hold_data", int'(out_data_a), 1);
        end
        check("bp_read_count", nreads, 2);
        check("bp_valid", int'(out_valid_a), 1);
        check("bp_busy", int'(busy_a), 1);
        cyc(1);
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid_a && out_ready) got.push_back(out_data_a);
        end
        check("bp_word_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) check("bp_order", int'(got[i]), i + 1);
        check("bp_busy_end", int'(busy_a), 0);

        // drain_en drops the cycle after a read
        do_reset();
        src.push_back(4'h7);
        src.push_back(4'h8);
        src.push_back(4'h9);
        out_ready = 1'b1;
        cyc(1);
        drain_en = 1'b1;
        @(negedge clk);
        check("den_read_c0", int'(fifo_read_a), 1);
        cyc(1);
        drain_en = 1'b0;
        @(negedge clk);
        check("den_read_c1", int'(fifo_read_a), 0);
        @(negedge clk);
        check("den_valid_c2", int'(out_valid_a), 1);
        check("den_data_c2", int'(out_data_a), 7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("den_no_read", int'(fifo_read_a), 0);
            check("den_no_valid", int'(out_valid_a), 0);
        end

        // Reset mid-operation with a buffered and an in-flight word
        do_reset();
        for (int w = 1; w <= 7; w++) src.push_back(4'(w));
        out_ready = 1'b1;
        cyc(1);
        drain_en = 1'b1;
        cyc(4);
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy_pre", int'(busy_a), 1);
        check("mid_data_pre", int'(out_data_a), 3);
        check("mid_count_pre", int'(pop_count_a), 2);
        cyc(1);
        reset = 1'b0;
        drain_en = 1'b0;
        @(negedge clk);
        check("mid_valid_post", int'(out_valid_a), 0);
        check("mid_busy_post", int'(busy_a), 0);
        check("mid_count_post", int'(pop_count_a), 0);
        check("mid_count_post_b", int'(pop_count_b), 0);
        check("mid_read_post", int'(fifo_read_a), 0);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
